// File: rtl/smachine_pkg.sv
// Shared definitions for the S-Machine execution core: opcode encodings,
// the control FSM state type and the bit positions inside the {Z,N,C}
// flag vector.
package smachine_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_ILL0 = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;
    localparam logic [3:0] OP_ILL1 = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM_WAIT,
        RETIRE
    } state_t;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 0;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == OP_ILL0) || (op == OP_ILL1);
    endfunction

endpackage

// File: rtl/smachine_exec_core_if.sv
// Instruction handshake and data-memory bus of the S-Machine core.
//   inst/inst_valid/inst_ready : instruction offer from the sequencer
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until mem_ack
//   mem_rdata/mem_ack : load data and one-cycle completion strobe
// slave  : the execution core's view
// master : the sequencer / memory environment's view
interface smachine_exec_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [15:0]       inst;
    logic              inst_valid;
    logic              inst_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  inst, inst_valid, mem_rdata, mem_ack,
        output inst_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output inst, inst_valid, mem_rdata, mem_ack,
        input  inst_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/smachine_alu.sv
// Combinational ALU of the S-Machine core. Computes the next A/B values,
// their write enables and the next {Z,N,C} flags for every non-memory
// opcode (LD immediate included).
//   opcode : inst[15:12]
//   imm    : inst[11:0]  ([11] selects B as R, [10:8] mode/flag bits, [7:0] data)
//   a, b   : current registers; flags : current {Z,N,C}
//   res_a, res_b, we_a, we_b : register updates; flags_nx : next flags
module smachine_alu
    import smachine_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [11:0]       imm,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        flags,
    output logic [DATA_W-1:0] res_a,
    output logic [DATA_W-1:0] res_b,
    output logic              we_a,
    output logic              we_b,
    output logic [2:0]        flags_nx
);

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] imm8;
    logic [DATA_W-1:0] val;
    logic              carry;
    logic              wr_r;
    logic              wr_a;
    logic              upd;

    always_comb begin
        wide     = '0;
        imm8     = DATA_W'(imm[7:0]);
        r        = imm[11] ? b : a;
        val      = '0;
        carry    = 1'b0;
        wr_r     = 1'b0;
        wr_a     = 1'b0;
        upd      = 1'b0;
        res_a    = a;
        res_b    = b;
        we_a     = 1'b0;
        we_b     = 1'b0;
        flags_nx = flags;

        case (opcode)
            OP_LD: begin
                // only the immediate form reaches here; memory LD is handled by the core
                if (imm[10]) begin
                    val  = imm[9] ? (imm8 << 8) : imm8;
                    wr_r = 1'b1;
                end
            end
            OP_INC: begin
                wide  = {1'b0, r} + {1'b0, imm8};
                val   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                wr_r  = 1'b1;
                upd   = 1'b1;
            end
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                val   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                wr_a  = 1'b1;
                upd   = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // the extra top bit of the difference is the unsigned borrow
                wide  = {1'b0, a} - {1'b0, b};
                val   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                wr_a  = (opcode == OP_SUB);
                upd   = 1'b1;
            end
            OP_OR: begin
                val  = a | b;
                wr_a = 1'b1;
                upd  = 1'b1;
            end
            OP_AND: begin
                val  = a & b;
                wr_a = 1'b1;
                upd  = 1'b1;
            end
            OP_XOR: begin
                val  = a ^ b;
                wr_a = 1'b1;
                upd  = 1'b1;
            end
            OP_SHR: begin
                val   = a >> 1;
                carry = a[0];
                wr_a  = 1'b1;
                upd   = 1'b1;
            end
            OP_MOV: begin
                res_b = a;
                we_b  = 1'b1;
            end
            OP_EXCH: begin
                res_a = b;
                res_b = a;
                we_a  = 1'b1;
                we_b  = 1'b1;
            end
            OP_SET: flags_nx = flags | imm[10:8];
            OP_CLR: flags_nx = flags & ~imm[10:8];
            default: ;
        endcase

        if (wr_r) begin
            if (imm[11]) begin
                res_b = val;
                we_b  = 1'b1;
            end else begin
                res_a = val;
                we_a  = 1'b1;
            end
        end
        if (wr_a) begin
            res_a = val;
            we_a  = 1'b1;
        end
        if (upd) begin
            flags_nx[FLAG_Z] = (val == '0);
            flags_nx[FLAG_N] = val[DATA_W-1];
            flags_nx[FLAG_C] = carry;
        end
    end

endmodule

// File: rtl/smachine_exec_core.sv
// S-Machine execution core. Accepts one instruction per handshake, executes
// it against A/B, performs LD/ST through a req/ack memory port and retires
// with a one-cycle done pulse (plus illegal for opcodes 0011/1111).
//   clk, rst  : clock, synchronous active-high reset
//   bus       : instruction handshake + data-memory port (slave modport)
//   done      : retire pulse; illegal : coincident pulse for illegal opcodes
//   pc        : retired-instruction counter (wraps)
//   flags     : {Z,N,C}; reg_a, reg_b : architectural registers
module smachine_exec_core
    import smachine_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 8,
    parameter int unsigned PC_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    smachine_exec_core_if.slave   bus,
    output logic                  done,
    output logic                  illegal,
    output logic [ADDR_W-1:0]     pc,
    output logic [2:0]            flags,
    output logic [DATA_W-1:0]     reg_a,
    output logic [DATA_W-1:0]     reg_b
);

    state_t            state;
    state_t            state_nx;
    logic [15:0]       ir;
    logic [3:0]        op;
    logic              is_mem;
    logic              handshake;
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;
    logic              we_a;
    logic              we_b;
    logic [2:0]        flags_nx;

    assign op        = ir[15:12];
    assign is_mem    = ((op == OP_LD) && !ir[10]) || (op == OP_ST);
    assign bus.inst_ready = (state == IDLE) && !rst;
    assign handshake = bus.inst_valid && bus.inst_ready;

    smachine_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode   (op),
        .imm      (ir[11:0]),
        .a        (reg_a),
        .b        (reg_b),
        .flags    (flags),
        .res_a    (res_a),
        .res_b    (res_b),
        .we_a     (we_a),
        .we_b     (we_b),
        .flags_nx (flags_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (handshake) state_nx = EXEC;
            EXEC:     state_nx = is_mem ? MEM_WAIT : RETIRE;
            MEM_WAIT: if (bus.mem_ack) state_nx = RETIRE;
            RETIRE:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // done/illegal are raised on the edge that enters RETIRE so the pulse
    // is visible during the RETIRE cycle itself
    always_ff @(posedge clk) begin
        if (rst) begin
            ir            <= '0;
            reg_a         <= '0;
            reg_b         <= '0;
            flags         <= '0;
            pc            <= ADDR_W'(PC_RESET);
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            done          <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) ir <= bus.inst;
                end
                EXEC: begin
                    if (is_mem) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= (op == OP_ST);
                        bus.mem_addr  <= ADDR_W'(ir[7:0]);
                        bus.mem_wdata <= ir[11] ? reg_b : reg_a;
                    end else begin
                        if (we_a) reg_a <= res_a;
                        if (we_b) reg_b <= res_b;
                        flags   <= flags_nx;
                        done    <= 1'b1;
                        illegal <= is_illegal(op);
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        done        <= 1'b1;
                        if (!bus.mem_we) begin
                            if (ir[11]) reg_b <= bus.mem_rdata;
                            else        reg_a <= bus.mem_rdata;
                        end
                    end
                end
                RETIRE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    pc      <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_smachine_exec_core.sv
// Directed self-checking bench for smachine_exec_core (16-bit and 32-bit builds).
module tb_smachine_exec_core;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] exp_pc;

    logic        done16, ill16;
    logic [7:0]  pc16;
    logic [2:0]  flags16;
    logic [15:0] a16, b16;

    logic        done32, ill32;
    logic [7:0]  pc32;
    logic [2:0]  flags32;
    logic [31:0] a32, b32;

    // results of the last run16 call
    int          r_lat, r_reqc;
    logic        r_ill, r_stab, r_we, r_late;
    logic [7:0]  r_addr;
    logic [15:0] r_wd;

    smachine_exec_core_if #(.DATA_W(16), .ADDR_W(8)) bus16 ();
    smachine_exec_core_if #(.DATA_W(32), .ADDR_W(8)) bus32 ();

    smachine_exec_core #(.DATA_W(16), .ADDR_W(8), .PC_RESET(0)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .done(done16), .illegal(ill16),
        .pc(pc16), .flags(flags16), .reg_a(a16), .reg_b(b16)
    );

    smachine_exec_core #(.DATA_W(32), .ADDR_W(8), .PC_RESET(0)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32), .done(done32), .illegal(ill32),
        .pc(pc32), .flags(flags32), .reg_a(a32), .reg_b(b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one instruction to the 16-bit core, serve its memory request
    // (ack after ack_wait MEM_WAIT cycles) and wait for done.
    // lat counts cycles with the handshake cycle as 1.
    task automatic run16(input logic [15:0] i, input int ack_wait, input logic [15:0] rdata);
        int   w;
        logic seen;
        w = 0; seen = 1'b0;
        r_lat = 0; r_reqc = 0; r_ill = 1'b0; r_stab = 1'b1; r_we = 1'b0;
        r_addr = '0; r_wd = '0; r_late = 1'b0;
        @(negedge clk);
        bus16.inst = i;
        bus16.inst_valid = 1'b1;
        @(posedge clk);
        #1 bus16.inst_valid = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            bus16.mem_ack = 1'b0;
            if (done16) begin
                seen  = 1'b1;
                r_lat = c + 1;
                r_ill = ill16;
            end else if (bus16.mem_req) begin
                if (r_reqc == 0) begin
                    r_we = bus16.mem_we; r_addr = bus16.mem_addr; r_wd = bus16.mem_wdata;
                end else if (bus16.mem_we !== r_we || bus16.mem_addr !== r_addr ||
                             bus16.mem_wdata !== r_wd) begin
                    r_stab = 1'b0;
                end
                r_reqc++;
                if (w == ack_wait) begin
                    bus16.mem_ack = 1'b1;
                    bus16.mem_rdata = rdata;
                end
                w++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout inst=%h got no done exp done within 40 cycles", i);
        end else begin
            exp_pc = exp_pc + 8'd1;
        end
        @(negedge clk);
        r_late = done16;
    endtask

    task automatic go(input logic [15:0] i);
        run16(i, 0, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus16.inst_ready !== 1'b0) begin errors++; $display("FAIL ready_in_rst got %b exp 0", bus16.inst_ready); end
        rst = 1'b0;
        @(negedge clk);
        exp_pc = 8'h00;
        checks++; if (a16 !== 16'h0 || b16 !== 16'h0) begin errors++; $display("FAIL rst_regs got a=%h b=%h exp 0", a16, b16); end
        checks++; if (flags16 !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", flags16); end
        checks++; if (pc16 !== 8'h00) begin errors++; $display("FAIL rst_pc got %h exp 00", pc16); end
        checks++; if (bus16.mem_req !== 1'b0 || bus16.mem_we !== 1'b0 || bus16.mem_addr !== 8'h0 || bus16.mem_wdata !== 16'h0)
            begin errors++; $display("FAIL rst_mem got req=%b we=%b addr=%h wd=%h exp all 0", bus16.mem_req, bus16.mem_we, bus16.mem_addr, bus16.mem_wdata); end
        checks++; if (done16 !== 1'b0 || ill16 !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%b ill=%b exp 0", done16, ill16); end
        checks++; if (bus16.inst_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus16.inst_ready); end
    endtask

    task automatic test_alu_basic();
        go(16'h0405);
        checks++; if (a16 !== 16'h0005 || r_lat != 3 || r_late !== 1'b0) begin errors++; $display("FAIL ld_imm_a got a=%h lat=%0d late=%b exp 0005 3 0", a16, r_lat, r_late); end
        go(16'h0C03);
        checks++; if (b16 !== 16'h0003 || r_lat != 3) begin errors++; $display("FAIL ld_imm_b got b=%h lat=%0d exp 0003 3", b16, r_lat); end
        go(16'h5000);
        checks++; if (a16 !== 16'h0002 || flags16 !== 3'b000 || r_lat != 3 || r_late !== 1'b0)
            begin errors++; $display("FAIL sub got a=%h f=%b lat=%0d late=%b exp 0002 000 3 0", a16, flags16, r_lat, r_late); end
        checks++; if (pc16 !== 8'h03) begin errors++; $display("FAIL pc_after3 got %h exp 03", pc16); end
    endtask

    task automatic test_add_cmp();
        go(16'h06FF);
        go(16'h20FF);
        checks++; if (a16 !== 16'hFFFF || flags16 !== 3'b010) begin errors++; $display("FAIL inc_a got a=%h f=%b exp FFFF 010", a16, flags16); end
        go(16'h0C01);
        go(16'h4000);
        checks++; if (a16 !== 16'h0000 || flags16 !== 3'b101) begin errors++; $display("FAIL add_carry got a=%h f=%b exp 0000 101", a16, flags16); end
        go(16'h0401);
        go(16'h0C02);
        go(16'hC000);
        checks++; if (a16 !== 16'h0001 || b16 !== 16'h0002 || flags16 !== 3'b011)
            begin errors++; $display("FAIL cmp got a=%h b=%h f=%b exp 0001 0002 011", a16, b16, flags16); end
        go(16'h28FE);
        checks++; if (b16 !== 16'h0100 || flags16 !== 3'b000) begin errors++; $display("FAIL inc_b got b=%h f=%b exp 0100 000", b16, flags16); end
        go(16'h6000);
        checks++; if (a16 !== 16'h0101) begin errors++; $display("FAIL or got a=%h exp 0101", a16); end
        go(16'hD700);
        checks++; if (flags16 !== 3'b111) begin errors++; $display("FAIL set got f=%b exp 111", flags16); end
        go(16'hE200);
        checks++; if (flags16 !== 3'b101) begin errors++; $display("FAIL clr got f=%b exp 101", flags16); end
        go(16'h7000);
        checks++; if (a16 !== 16'h0100 || flags16 !== 3'b000) begin errors++; $display("FAIL and got a=%h f=%b exp 0100 000", a16, flags16); end
        go(16'h8000);
        checks++; if (a16 !== 16'h0000 || flags16 !== 3'b100) begin errors++; $display("FAIL xor got a=%h f=%b exp 0000 100", a16, flags16); end
        go(16'hB000);
        checks++; if (a16 !== 16'h0100 || b16 !== 16'h0000 || flags16 !== 3'b100)
            begin errors++; $display("FAIL exch got a=%h b=%h f=%b exp 0100 0000 100", a16, b16, flags16); end
        go(16'hA000);
        checks++; if (b16 !== 16'h0100) begin errors++; $display("FAIL mov got b=%h exp 0100", b16); end
        checks++; if (pc16 !== 8'd18) begin errors++; $display("FAIL pc_after18 got %0d exp 18", pc16); end
    endtask

    task automatic test_mem();
        go(16'h0477);
        run16(16'h1010, 3, 16'h0000);
        checks++; if (r_we !== 1'b1 || r_addr !== 8'h10 || r_wd !== 16'h0077)
            begin errors++; $display("FAIL st_bus got we=%b addr=%h wd=%h exp 1 10 0077", r_we, r_addr, r_wd); end
        checks++; if (r_reqc != 4 || r_stab !== 1'b1) begin errors++; $display("FAIL st_hold got cycles=%0d stable=%b exp 4 1", r_reqc, r_stab); end
        checks++; if (r_lat != 7 || r_late !== 1'b0) begin errors++; $display("FAIL st_latency got lat=%0d late=%b exp 7 0", r_lat, r_late); end
        checks++; if (bus16.mem_req !== 1'b0) begin errors++; $display("FAIL st_req_drop got %b exp 0", bus16.mem_req); end
        // stray ack while idle must be ignored
        @(negedge clk);
        bus16.mem_ack = 1'b1; bus16.mem_rdata = 16'hBEEF;
        @(negedge clk);
        bus16.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (a16 !== 16'h0077 || b16 !== 16'h0100 || done16 !== 1'b0 || pc16 !== exp_pc)
            begin errors++; $display("FAIL idle_ack got a=%h b=%h done=%b pc=%h exp 0077 0100 0 %h", a16, b16, done16, pc16, exp_pc); end
        run16(16'h0810, 0, 16'h1234);
        checks++; if (b16 !== 16'h1234 || a16 !== 16'h0077 || flags16 !== 3'b100)
            begin errors++; $display("FAIL ld_mem got a=%h b=%h f=%b exp 0077 1234 100", a16, b16, flags16); end
        checks++; if (r_we !== 1'b0 || r_addr !== 8'h10 || r_lat != 4)
            begin errors++; $display("FAIL ld_mem_bus got we=%b addr=%h lat=%0d exp 0 10 4", r_we, r_addr, r_lat); end
    endtask

    task automatic test_reset_mem();
        @(negedge clk);
        bus16.inst = 16'h0020;
        bus16.inst_valid = 1'b1;
        @(posedge clk);
        #1 bus16.inst_valid = 1'b0;
        for (int c = 0; c < 10 && bus16.mem_req !== 1'b1; c++) @(negedge clk);
        checks++; if (bus16.mem_req !== 1'b1) begin errors++; $display("FAIL rm_req got %b exp 1", bus16.mem_req); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus16.mem_req !== 1'b0 || a16 !== 16'h0 || b16 !== 16'h0 || bus16.inst_ready !== 1'b0)
            begin errors++; $display("FAIL rm_abort got req=%b a=%h b=%h rdy=%b exp 0 0 0 0", bus16.mem_req, a16, b16, bus16.inst_ready); end
        rst = 1'b0;
        bus16.mem_ack = 1'b1; bus16.mem_rdata = 16'h5555;
        @(negedge clk);
        bus16.mem_ack = 1'b0;
        exp_pc = 8'h00;
        checks++; if (bus16.inst_ready !== 1'b1 || a16 !== 16'h0 || done16 !== 1'b0 || pc16 !== 8'h00 || bus16.mem_req !== 1'b0)
            begin errors++; $display("FAIL rm_late_ack got rdy=%b a=%h done=%b pc=%h req=%b exp 1 0 0 00 0", bus16.inst_ready, a16, done16, pc16, bus16.mem_req); end
    endtask

    task automatic test_illegal();
        go(16'h0412);
        go(16'h0C34);
        go(16'hD100);
        go(16'hF000);
        checks++; if (r_ill !== 1'b1 || a16 !== 16'h0012 || b16 !== 16'h0034 || flags16 !== 3'b001)
            begin errors++; $display("FAIL ill_f got ill=%b a=%h b=%h f=%b exp 1 0012 0034 001", r_ill, a16, b16, flags16); end
        go(16'h3000);
        checks++; if (r_ill !== 1'b1 || pc16 !== 8'h05 || flags16 !== 3'b001)
            begin errors++; $display("FAIL ill_3 got ill=%b pc=%h f=%b exp 1 05 001", r_ill, pc16, flags16); end
        go(16'h0401);
        checks++; if (r_ill !== 1'b0) begin errors++; $display("FAIL ill_legal got %b exp 0", r_ill); end
        for (int n = 0; n < 300 && exp_pc != 8'hFF; n++) go(16'h3000);
        checks++; if (pc16 !== 8'hFF) begin errors++; $display("FAIL pc_ff got %h exp FF", pc16); end
        go(16'hF000);
        checks++; if (pc16 !== 8'h00 || r_ill !== 1'b1) begin errors++; $display("FAIL pc_wrap got pc=%h ill=%b exp 00 1", pc16, r_ill); end
    endtask

    task automatic run32(input logic [15:0] i);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus32.inst = i;
        bus32.inst_valid = 1'b1;
        @(posedge clk);
        #1 bus32.inst_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL done32_timeout inst=%h got no done exp done within 20 cycles", i); end
        @(negedge clk);
    endtask

    task automatic test_wide();
        run32(16'h06AB);
        checks++; if (a32 !== 32'h0000AB00) begin errors++; $display("FAIL w_ld_hi got a=%h exp 0000AB00", a32); end
        run32(16'h0401);
        run32(16'h9000);
        checks++; if (a32 !== 32'h0 || flags32 !== 3'b101) begin errors++; $display("FAIL w_shr got a=%h f=%b exp 0 101", a32, flags32); end
    endtask

    initial begin
        checks = 0; errors = 0; exp_pc = 8'h00;
        rst = 1'b1;
        bus16.inst = '0; bus16.inst_valid = 1'b0; bus16.mem_ack = 1'b0; bus16.mem_rdata = '0;
        bus32.inst = '0; bus32.inst_valid = 1'b0; bus32.mem_ack = 1'b0; bus32.mem_rdata = '0;
        test_reset();
        test_alu_basic();
        test_add_cmp();
        test_mem();
        test_reset_mem();
        test_illegal();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
